// File: rtl/player_motion.sv
// player_motion
//   Per-player movement and animation engine. Advances once per frame_tick:
//   horizontal walking with screen-edge clamping, jump / gravity physics,
//   landing on the floor or on a single platform, and a six-step walk cycle.
//
// Ports
//   clk          pixel clock
//   rst_n        synchronous active-low reset
//   frame_tick   one-cycle pulse per video frame; all state advances only then
//   buttons[7:0] debounced, active-low: [0] right, [1] left, [3] jump
//   plt_x/plt_y  platform top-left corner, stable between ticks
//   char_x/y     sprite top-left corner
//   facing_right sprite faces right
//   anim_frame   walk-cycle frame 0..5
//   airborne     high while rising or falling
module player_motion #(
  parameter int CHAR_W   = 46,
  parameter int CHAR_H   = 60,
  parameter int PLT_W    = 100,
  parameter int SPEED    = 5,
  parameter int JUMP_V   = 12,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 10,
  parameter int X_MAX    = 594,
  parameter int FLOOR_Y  = 420,
  parameter int START_X  = 100,
  parameter int ANIM_DIV = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [7:0] buttons,
  input  logic [9:0] plt_x,
  input  logic [9:0] plt_y,
  output logic [9:0] char_x,
  output logic [9:0] char_y,
  output logic       facing_right,
  output logic [2:0] anim_frame,
  output logic       airborne
);

  typedef enum logic [1:0] {GROUNDED, RISING, FALLING} state_t;

  localparam logic signed [5:0]  VY_JUMP  = 6'(-JUMP_V);
  localparam logic signed [10:0] GRAV_S   = 11'(GRAVITY);
  localparam logic signed [10:0] MAXF_S   = 11'(MAX_FALL);
  localparam logic signed [10:0] FLOOR_S  = 11'(FLOOR_Y);
  localparam logic signed [10:0] CHAR_H_S = 11'(CHAR_H);
  localparam logic [7:0]         ANIM_TOP = 8'(ANIM_DIV - 1);

  state_t            state, state_next;
  logic signed [5:0] vy, vy_next;
  logic [9:0]        x_next, y_next;
  logic              facing_next;
  logic [2:0]        anim_next;
  logic [7:0]        anim_cnt, anim_cnt_next;
  logic              jump_prev;

  logic              right_only, left_only, jump_edge, overlap;
  logic [10:0]       x_sum, old_bottom;
  logic signed [10:0] vy_ext, y_sum, vy_grav, vy_cap, new_bottom, plt_y_s;
  logic              land_plt, land_floor;
  logic              unused_buttons;

  assign unused_buttons = ^{buttons[7:4], buttons[2]};

  assign right_only = ~buttons[0] &  buttons[1];
  assign left_only  =  buttons[0] & ~buttons[1];
  // A jump fires only on a press edge seen across two ticks, never while held.
  assign jump_edge  = jump_prev & ~buttons[3];

  // Horizontal step with clamping at both screen edges.
  assign x_sum = {1'b0, char_x} + 11'(SPEED);

  always_comb begin
    x_next      = char_x;
    facing_next = facing_right;
    if (right_only) begin
      x_next      = (x_sum > 11'(X_MAX)) ? 10'(X_MAX) : x_sum[9:0];
      facing_next = 1'b1;
    end else if (left_only) begin
      x_next      = (char_x < 10'(SPEED)) ? 10'd0 : char_x - 10'(SPEED);
      facing_next = 1'b0;
    end
  end

  // Overlap is judged against this tick's new x position.
  assign overlap = (({1'b0, x_next} + 11'(CHAR_W)) > {1'b0, plt_x}) &&
                   ({1'b0, x_next} < ({1'b0, plt_x} + 11'(PLT_W)));

  // Vertical arithmetic in 11-bit signed so nothing wraps near the edges.
  assign vy_ext     = {{5{vy[5]}}, vy};
  assign y_sum      = $signed({1'b0, char_y}) + vy_ext;
  assign vy_grav    = vy_ext + GRAV_S;
  assign vy_cap     = (vy_grav > MAXF_S) ? MAXF_S : vy_grav;
  assign old_bottom = {1'b0, char_y} + 11'(CHAR_H);
  assign new_bottom = y_sum + CHAR_H_S;
  assign plt_y_s    = $signed({1'b0, plt_y});

  assign land_plt   = (vy > 6'sd0) && (old_bottom <= {1'b0, plt_y}) &&
                      (new_bottom >= plt_y_s) && overlap;
  assign land_floor = (y_sum >= FLOOR_S);

  // Next-state, vertical motion and animation for one frame.
  always_comb begin
    state_next    = state;
    vy_next       = vy;
    y_next        = char_y;
    anim_next     = anim_frame;
    anim_cnt_next = anim_cnt;
    case (state)
      GROUNDED: begin
        if (jump_edge) begin
          vy_next    = VY_JUMP;
          state_next = RISING;
        end else if ((old_bottom == {1'b0, plt_y}) && !overlap) begin
          // Walked off the platform edge.
          vy_next    = 6'sd0;
          state_next = FALLING;
        end
        if (right_only || left_only) begin
          if (anim_cnt == ANIM_TOP) begin
            anim_cnt_next = 8'd0;
            anim_next     = (anim_frame == 3'd5) ? 3'd0 : anim_frame + 3'd1;
          end else begin
            anim_cnt_next = anim_cnt + 8'd1;
          end
        end else begin
          anim_cnt_next = 8'd0;
          anim_next     = 3'd0;
        end
      end
      default: begin
        // Platform landing wins over floor landing on the same tick.
        if (land_plt) begin
          y_next     = plt_y - 10'(CHAR_H);
          vy_next    = 6'sd0;
          state_next = GROUNDED;
        end else if (land_floor) begin
          y_next     = 10'(FLOOR_Y);
          vy_next    = 6'sd0;
          state_next = GROUNDED;
        end else if (y_sum < 11'sd0) begin
          y_next     = 10'd0;
          vy_next    = 6'sd0;
          state_next = FALLING;
        end else begin
          y_next     = y_sum[9:0];
          vy_next    = vy_cap[5:0];
          state_next = (vy_cap >= 11'sd0) ? FALLING : RISING;
        end
      end
    endcase
  end

  // State register; reset beats frame_tick, otherwise everything holds between ticks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= GROUNDED;
      vy           <= 6'sd0;
      char_x       <= 10'(START_X);
      char_y       <= 10'(FLOOR_Y);
      facing_right <= 1'b1;
      anim_frame   <= 3'd0;
      anim_cnt     <= 8'd0;
      airborne     <= 1'b0;
      jump_prev    <= 1'b1;
    end else if (frame_tick) begin
      state        <= state_next;
      vy           <= vy_next;
      char_x       <= x_next;
      char_y       <= y_next;
      facing_right <= facing_next;
      anim_frame   <= anim_next;
      anim_cnt     <= anim_cnt_next;
      airborne     <= (state_next != GROUNDED);
      jump_prev    <= buttons[3];
    end
  end

endmodule
